sound_dma_ctrl: RTL and testbench

- Sequences ISA single-mode DMA cycles for the Sound Blaster DSP.
- Arbitrates the DSP's 8-bit (channel 1) and 16-bit (channel 5) requests onto the ISA DRQ/DACK pins.
- Moves one byte/word per grant between the ISA data bus and the DSP DMA port, and pulses dma_ack to the DSP.
- Sits between sound_dsp and the ISA card edge, clocked by the sound clk.

---
 rtl/sound_dma_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_sound_dma_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sound_dma_ctrl.sv
// sound_dma_ctrl: ISA single-mode DMA sequencer for the Sound Blaster DSP (DRQ1/DACK1# 8-bit, DRQ5/DACK5# 16-bit).
// Define SOUND_DMA_TIMEOUT_EN to abort a REQ phase that waits longer than TIMEOUT_US ce_1us ticks for DACK.
module sound_dma_ctrl #(
  parameter int TIMEOUT_US = 1000,
  parameter int HOLDOFF    = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ce_1us,
  input  logic        rec,
  input  logic        req8,
  input  logic        req16,
  output logic        dma_ack,
  output logic [15:0] dma_readdata,
  input  logic [15:0] dma_writedata,
  output logic        isa_drq1,
  output logic        isa_drq5,
  input  logic        isa_dack1_n,
  input  logic        isa_dack5_n,
  input  logic        isa_ior_n,
  input  logic        isa_iow_n,
  input  logic [15:0] isa_d_in,
  output logic [15:0] isa_d_out,
  output logic        isa_d_oe,
  output logic        timeout_err,
  input  logic        clr_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_XFER = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [7:0] HOLD_LOAD = 8'(HOLDOFF);

  state_t      state_q;
  logic        ch_q;            // 0 = channel 1 (8-bit), 1 = channel 5 (16-bit)
  logic        rec_q;
  logic        last_grant_q;
  logic        strobe_seen_q;
  logic [7:0]  holdoff_q;
  logic [15:0] cap_q;
  logic [15:0] wdata_q;
  logic [15:0] rdata_q;
  logic        drq1_q;
  logic        drq5_q;
  logic        ack_q;
  logic [3:0]  sync1_q;         // {dack5_n, dack1_n, ior_n, iow_n}
  logic [3:0]  sync2_q;
  logic [1:0]  strb_prev_q;     // previous synchronised {ior_n, iow_n}

  logic        act_dack_n;
  logic        act_strobe;
  logic        prev_strobe;
  logic        strobe_fall;
  logic        strobe_rise;
  logic        grant_ch;
  logic        timeout_hit;
  logic [15:0] wdata_d;
  logic [15:0] rdata_d;

  always_comb begin
    act_dack_n  = ch_q  ? sync2_q[3]     : sync2_q[2];
    act_strobe  = rec_q ? sync2_q[1]     : sync2_q[0];
    prev_strobe = rec_q ? strb_prev_q[1] : strb_prev_q[0];
    strobe_fall = prev_strobe & ~act_strobe;
    strobe_rise = ~prev_strobe & act_strobe;
    if (req8 && req16) begin
      grant_ch = ~last_grant_q;
    end else if (req16) begin
      grant_ch = 1'b1;
    end else begin
      grant_ch = 1'b0;
    end
    wdata_d = grant_ch ? dma_writedata : {8'h00, dma_writedata[7:0]};
    rdata_d = ch_q ? cap_q : {8'h00, cap_q[7:0]};
  end

`ifdef SOUND_DMA_TIMEOUT_EN
  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_US);

  logic [15:0] to_cnt_q;
  logic        err_q;

  // A DACK arriving in the same cycle as the limit still wins over the timeout.
  assign timeout_hit = (state_q == S_REQ) && act_dack_n && (to_cnt_q >= TO_LIMIT);
  assign timeout_err = err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      to_cnt_q <= 16'd0;
      err_q    <= 1'b0;
    end else begin
      if (state_q != S_REQ) begin
        to_cnt_q <= 16'd0;
      end else if (ce_1us && (to_cnt_q < TO_LIMIT)) begin
        to_cnt_q <= to_cnt_q + 16'd1;
      end
      if (timeout_hit) begin
        err_q <= 1'b1;
      end else if (clr_err) begin
        err_q <= 1'b0;
      end
    end
  end
`else
  logic unused_timeout_inputs;

  assign unused_timeout_inputs = ce_1us ^ clr_err;
  assign timeout_hit           = 1'b0;
  assign timeout_err           = 1'b0;
`endif

  assign dma_ack      = ack_q;
  assign dma_readdata = rdata_q;
  assign isa_drq1     = drq1_q;
  assign isa_drq5     = drq5_q;
  assign isa_d_out    = wdata_q;
  // Bus drive must follow the raw pins so the card releases the bus as soon as the host does.
  assign isa_d_oe     = rec_q && ((state_q == S_REQ) || (state_q == S_XFER)) &&
                        !(ch_q ? isa_dack5_n : isa_dack1_n) && !isa_ior_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      ch_q          <= 1'b0;
      rec_q         <= 1'b0;
      last_grant_q  <= 1'b1;
      strobe_seen_q <= 1'b0;
      holdoff_q     <= 8'd0;
      cap_q         <= 16'h0000;
      wdata_q       <= 16'h0000;
      rdata_q       <= 16'h0000;
      drq1_q        <= 1'b0;
      drq5_q        <= 1'b0;
      ack_q         <= 1'b0;
      sync1_q       <= 4'hF;
      sync2_q       <= 4'hF;
      strb_prev_q   <= 2'b11;
    end else begin
      sync1_q     <= {isa_dack5_n, isa_dack1_n, isa_ior_n, isa_iow_n};
      sync2_q     <= sync1_q;
      strb_prev_q <= sync2_q[1:0];
      ack_q       <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (holdoff_q != 8'd0) begin
            holdoff_q <= holdoff_q - 8'd1;
          end else if (req8 || req16) begin
            ch_q          <= grant_ch;
            rec_q         <= rec;
            wdata_q       <= wdata_d;
            drq1_q        <= ~grant_ch;
            drq5_q        <= grant_ch;
            strobe_seen_q <= 1'b0;
            state_q       <= S_REQ;
          end
        end
        S_REQ: begin
          if (!act_dack_n) begin
            state_q <= S_XFER;
          end else if (timeout_hit) begin
            drq1_q    <= 1'b0;
            drq5_q    <= 1'b0;
            holdoff_q <= HOLD_LOAD;
            state_q   <= S_IDLE;
          end
        end
        S_XFER: begin
          if (!act_strobe) begin
            cap_q         <= isa_d_in;
            strobe_seen_q <= 1'b1;
          end
          if (strobe_fall) begin
            drq1_q <= 1'b0;
            drq5_q <= 1'b0;
          end
          if (strobe_rise && strobe_seen_q) begin
            state_q <= S_DONE;
          end else if (act_dack_n && act_strobe && !strobe_seen_q) begin
            // Host withdrew DACK without a strobe: abandon the cycle silently.
            drq1_q    <= 1'b0;
            drq5_q    <= 1'b0;
            holdoff_q <= HOLD_LOAD;
            state_q   <= S_IDLE;
          end
        end
        S_DONE: begin
          ack_q        <= 1'b1;
          rdata_q      <= rdata_d;
          last_grant_q <= ch_q;
          drq1_q       <= 1'b0;
          drq5_q       <= 1'b0;
          holdoff_q    <= HOLD_LOAD;
          state_q      <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sound_dma_ctrl.sv
// Scoreboard bench for sound_dma_ctrl: the bench acts as DSP and ISA host, a monitor checks every dma_ack.
`timescale 1ns/1ps
module tb_sound_dma_ctrl;

`ifdef SOUND_DMA_TIMEOUT_EN
  localparam int TO_US = 10;
`else
  localparam int TO_US = 1000;
`endif
  localparam int HOLD = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ce_1us = 1'b0;
  logic        rec = 1'b0;
  logic        req8 = 1'b0;
  logic        req16 = 1'b0;
  logic        dma_ack;
  logic [15:0] dma_readdata;
  logic [15:0] dwr = 16'h0000;
  logic        isa_drq1;
  logic        isa_drq5;
  logic        dack1_n = 1'b1;
  logic        dack5_n = 1'b1;
  logic        ior_n = 1'b1;
  logic        iow_n = 1'b1;
  logic [15:0] din = 16'h0000;
  logic [15:0] isa_d_out;
  logic        isa_d_oe;
  logic        timeout_err;
  logic        clr_err = 1'b0;

  int          n_checks = 0;
  int          n_fail = 0;
  int          ack_cnt = 0;
  logic [15:0] exp_q[$];
  logic        m_last16 = 1'b1;   // reference: channel serviced most recently (1 = 16-bit)
  logic        ack_prev = 1'b0;

  sound_dma_ctrl #(.TIMEOUT_US(TO_US), .HOLDOFF(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .ce_1us(ce_1us), .rec(rec), .req8(req8), .req16(req16),
    .dma_ack(dma_ack), .dma_readdata(dma_readdata), .dma_writedata(dwr),
    .isa_drq1(isa_drq1), .isa_drq5(isa_drq5), .isa_dack1_n(dack1_n), .isa_dack5_n(dack5_n),
    .isa_ior_n(ior_n), .isa_iow_n(iow_n), .isa_d_in(din), .isa_d_out(isa_d_out),
    .isa_d_oe(isa_d_oe), .timeout_err(timeout_err), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  // 1 MHz strobe stand-in: one cycle high in every four, changed on the falling edge
  initial begin
    forever begin
      repeat (3) @(negedge clk);
      ce_1us = 1'b1;
      @(negedge clk);
      ce_1us = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic pick(input logic r8, input logic r16);
    if (r8 && r16) return ~m_last16;
    return r16;
  endfunction

  // monitor: DRQ exclusivity every cycle, scoreboard pop on every ack
  always @(negedge clk) begin
    logic [15:0] e;
    if (rst_n) begin
      chk("drq_exclusive", 32'(isa_drq1 & isa_drq5), 32'd0);
      if (dma_ack) begin
        chk("ack_one_cycle", 32'(ack_prev), 32'd0);
        ack_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_ack: got ack with readdata %0h, expected no ack", dma_readdata);
        end else begin
          e = exp_q.pop_front();
          chk("readdata", 32'(dma_readdata), 32'(e));
        end
      end
    end
    ack_prev = dma_ack;
  end

  // one complete host-side DMA cycle on channel ch16 with strobe held low for slen cycles
  task automatic xfer(input logic ch16, input logic rv, input logic [15:0] wd,
                      input logic [15:0] dv, input int slen);
    logic [15:0] exp_out;
    int          t;
    int          start;
    exp_q.push_back(ch16 ? dv : {8'h00, dv[7:0]});
    exp_out = ch16 ? wd : {8'h00, wd[7:0]};
    for (int i = 0; i < 20 && !(ch16 ? isa_drq5 : isa_drq1); i++) cyc(1);
    chk("grant_drq", 32'(ch16 ? isa_drq5 : isa_drq1), 32'd1);
    chk("d_out", 32'(isa_d_out), 32'(exp_out));
    dwr = 16'($urandom);
    if (ch16) dack5_n = 1'b0; else dack1_n = 1'b0;
    cyc(3);
    chk("d_oe_no_strobe", 32'(isa_d_oe), 32'd0);
    din = dv;
    if (rv) ior_n = 1'b0; else iow_n = 1'b0;
    t = -1;
    for (int i = 0; i < slen; i++) begin
      cyc(1);
      chk("d_oe_strobe", 32'(isa_d_oe), 32'(rv));
      if (t < 0 && !(ch16 ? isa_drq5 : isa_drq1)) t = i + 1;
    end
    chk("drq_fall_latency", 32'(t >= 1 && t <= 3), 32'd1);
    start = ack_cnt;
    ior_n = 1'b1;
    iow_n = 1'b1;
    for (int i = 0; i < 10 && ack_cnt == start; i++) cyc(1);
    chk("ack_seen", 32'(ack_cnt - start), 32'd1);
    chk("d_oe_after", 32'(isa_d_oe), 32'd0);
    dack1_n = 1'b1;
    dack5_n = 1'b1;
    din = 16'($urandom);
    m_last16 = ch16;
  endtask

  initial begin
    logic        ch;
    logic [15:0] v;
    logic [1:0]  p;
    int          cnt;
    int          start;

    cyc(3);
    chk("rst_drq1", 32'(isa_drq1), 32'd0);
    chk("rst_drq5", 32'(isa_drq5), 32'd0);
    chk("rst_ack", 32'(dma_ack), 32'd0);
    chk("rst_rdata", 32'(dma_readdata), 32'd0);
    chk("rst_dout", 32'(isa_d_out), 32'd0);
    chk("rst_oe", 32'(isa_d_oe), 32'd0);
    chk("rst_err", 32'(timeout_err), 32'd0);
    rst_n = 1'b1;
    cyc(2);

    // playback 8-bit, DRQ1 one clock after the request
    rec = 1'b0;
    dwr = 16'hBEEF;
    req8 = 1'b1;
    cyc(1);
    chk("drq1_rise_1clk", 32'(isa_drq1), 32'd1);
    xfer(1'b0, 1'b0, 16'hBEEF, 16'hA55A, 4);
    req8 = 1'b0;
    cyc(6);

    // record 16-bit
    rec = 1'b1;
    dwr = 16'h1234;
    req16 = 1'b1;
    v = 16'($urandom);
    xfer(1'b1, 1'b1, 16'h1234, v, 4);
    req16 = 1'b0;
    rec = 1'b0;
    cyc(6);

    // both requests held: round robin
    req8 = 1'b1;
    req16 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      ch = pick(1'b1, 1'b1);
      v = dwr;
      xfer(ch, 1'b0, v, 16'($urandom), 4);
    end
    req8 = 1'b0;
    req16 = 1'b0;
    cyc(6);

    // randomized traffic
    for (int k = 0; k < 16; k++) begin
      p = 2'($urandom_range(1, 3));
      rec = 1'($urandom);
      dwr = 16'($urandom);
      req8 = p[0];
      req16 = p[1];
      ch = pick(p[0], p[1]);
      v = dwr;
      xfer(ch, rec, v, 16'($urandom), int'($urandom_range(4, 6)));
    end
    req8 = 1'b0;
    req16 = 1'b0;
    rec = 1'b0;
    cyc(6);

    // aborted cycle on channel 5
    dwr = 16'h0F0F;
    req16 = 1'b1;
    for (int i = 0; i < 20 && !isa_drq5; i++) cyc(1);
    start = ack_cnt;
    dack5_n = 1'b0;
    cyc(3);
    dack5_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10 && isa_drq5; i++) begin cyc(1); cnt++; end
    chk("abort_drq_drop", 32'(cnt >= 1 && cnt <= 4 && !isa_drq5), 32'd1);
    cnt = 0;
    for (int i = 0; i < 20 && !isa_drq5; i++) begin cyc(1); cnt++; end
    chk("abort_holdoff", 32'(cnt >= HOLD + 1 && isa_drq5), 32'd1);
    chk("abort_no_ack", 32'(ack_cnt - start), 32'd0);
    xfer(1'b1, 1'b0, 16'h0F0F, 16'h7E81, 5);
    req16 = 1'b0;
    cyc(6);

    // REQ with no DACK
    dwr = 16'h00C3;
    start = ack_cnt;
    req8 = 1'b1;
    for (int i = 0; i < 20 && !isa_drq1; i++) cyc(1);
`ifdef SOUND_DMA_TIMEOUT_EN
    cnt = 0;
    for (int i = 0; i < 400; i++) begin
      cyc(1);
      if (!isa_drq1) break;
      if (ce_1us) cnt++;
    end
    req8 = 1'b0;
    chk("timeout_ticks", 32'(cnt), 32'(TO_US));
    chk("timeout_drq1", 32'(isa_drq1), 32'd0);
    chk("timeout_err_set", 32'(timeout_err), 32'd1);
    cyc(2);
    chk("timeout_err_sticky", 32'(timeout_err), 32'd1);
    chk("timeout_no_ack", 32'(ack_cnt - start), 32'd0);
    clr_err = 1'b1;
    cyc(1);
    clr_err = 1'b0;
    chk("timeout_err_clr", 32'(timeout_err), 32'd0);
`else
    cyc(40);
    chk("no_timeout_drq1", 32'(isa_drq1), 32'd1);
    chk("no_timeout_err", 32'(timeout_err), 32'd0);
    clr_err = 1'b1;
    cyc(1);
    clr_err = 1'b0;
    xfer(1'b0, 1'b0, 16'h00C3, 16'h3C96, 4);
    req8 = 1'b0;
`endif
    cyc(6);

    // reset in the middle of a playback transfer
    dwr = 16'h5555;
    req8 = 1'b1;
    for (int i = 0; i < 20 && !isa_drq1; i++) cyc(1);
    dack1_n = 1'b0;
    cyc(3);
    iow_n = 1'b0;
    din = 16'h1111;
    cyc(1);
    rst_n = 1'b0;
    cyc(1);
    chk("midrst_drq1", 32'(isa_drq1), 32'd0);
    chk("midrst_drq5", 32'(isa_drq5), 32'd0);
    chk("midrst_oe", 32'(isa_d_oe), 32'd0);
    chk("midrst_ack", 32'(dma_ack), 32'd0);
    dack1_n = 1'b1;
    iow_n = 1'b1;
    req8 = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    m_last16 = 1'b1;
    dwr = 16'h9876;
    req8 = 1'b1;
    req16 = 1'b1;
    ch = pick(1'b1, 1'b1);
    xfer(ch, 1'b0, 16'h9876, 16'hCAFE, 4);
    req8 = 1'b0;
    req16 = 1'b0;
    cyc(10);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
